unidad_de_control: RTL and testbench

//  Multi-cycle control unit directly upstream of the 16-bit datapath. Fetches 16-bit instructions

---
 rtl/unidad_de_control_pkg.sv | 48 ++++
 rtl/unidad_de_control_decodificador_instr.sv | 80 ++++++++
 rtl/unidad_de_control.sv | 134 +++++++++++++
 tb/tb_unidad_de_control.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_de_control_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, instruction classes,
// function-select and branch-condition codes, plus the branch helper functions.
package unidad_de_control_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } stateT;

   localparam logic [2:0] CLASS_ALU_REG = 3'b000;
   localparam logic [2:0] CLASS_LOAD    = 3'b001;
   localparam logic [2:0] CLASS_STORE   = 3'b010;
   localparam logic [2:0] CLASS_ALU_IMM = 3'b100;
   localparam logic [2:0] CLASS_BRANCH  = 3'b110;
   localparam logic [2:0] CLASS_JUMP    = 3'b111;

   localparam logic [3:0] FS_PASS_A   = 4'b0000;

   localparam logic [3:0] COND_Z      = 4'b0000;
   localparam logic [3:0] COND_N      = 4'b0001;
   localparam logic [3:0] COND_C      = 4'b0010;
   localparam logic [3:0] COND_V      = 4'b0011;
   localparam logic [3:0] COND_ALWAYS = 4'b0100;
   localparam logic [3:0] SUBOP_HALT  = 4'b1111;

   // Any sub-op outside the defined condition codes means "never taken".
   function automatic logic condMet(input logic [3:0] cond, input logic v, input logic z,
                                    input logic n, input logic c);
      logic met;
      met = 1'b0;
      case (cond)
         COND_Z:      met = z;
         COND_N:      met = n;
         COND_C:      met = c;
         COND_V:      met = v;
         COND_ALWAYS: met = 1'b1;
         default:     met = 1'b0;
      endcase
      return met;
   endfunction

   // The PC has already been incremented, so the offset is relative to the next instruction.
   function automatic logic [15:0] branchTarget(input logic [15:0] pc, input logic [5:0] offset);
      return pc + {{10{offset[5]}}, offset};
   endfunction

endpackage

// File: rtl/unidad_de_control_decodificador_instr.sv
// Combinational decoder: instruction class/sub-op, FSM state and datapath flags -> control word.
// With CONTROL_TRAP_EN defined, illegal classes raise trapReq instead of acting as a NOP.
module decodificador_instr
   import unidad_de_control_pkg::*;
(
   input  stateT       state,
   input  logic [2:0]  opClass,
   input  logic [3:0]  subOp,
   input  logic        V,
   input  logic        Z,
   input  logic        N,
   input  logic        C,
   output logic [3:0]  fs,
   output logic        mbSelect,
   output logic        mdSelect,
   output logic        rw,
   output logic        mw,
   output logic        branchTaken,
   output logic        jumpTaken,
   output logic        haltReq
`ifdef CONTROL_TRAP_EN
   ,
   output logic        trapReq
`endif
);

   // The control word is only live during EXEC; every other state presents an idle word.
   always_comb begin
      fs          = 4'd0;
      mbSelect    = 1'b0;
      mdSelect    = 1'b0;
      rw          = 1'b0;
      mw          = 1'b0;
      branchTaken = 1'b0;
      jumpTaken   = 1'b0;
      haltReq     = 1'b0;
`ifdef CONTROL_TRAP_EN
      trapReq     = 1'b0;
`endif
      if (state == EXEC) begin
         case (opClass)
            CLASS_ALU_REG: begin
               fs = subOp;
               rw = 1'b1;
            end
            CLASS_LOAD: begin
               fs       = FS_PASS_A;
               mdSelect = 1'b1;
               rw       = 1'b1;
            end
            CLASS_STORE: begin
               mw = 1'b1;
            end
            CLASS_ALU_IMM: begin
               fs       = subOp;
               mbSelect = 1'b1;
               rw       = 1'b1;
            end
            CLASS_BRANCH: begin
               fs          = FS_PASS_A;
               branchTaken = condMet(subOp, V, Z, N, C);
            end
            CLASS_JUMP: begin
               if (subOp == SUBOP_HALT) begin
                  haltReq = 1'b1;
               end else begin
                  fs        = FS_PASS_A;
                  jumpTaken = 1'b1;
               end
            end
            default: begin
`ifdef CONTROL_TRAP_EN
               trapReq = 1'b1;
`endif
            end
         endcase
      end
   end

endmodule

// File: rtl/unidad_de_control.sv
// Multi-cycle control unit: fetches over a req/ack port, holds PC/IR and drives the datapath.
// Optional feature macro CONTROL_TRAP_EN adds the sticky illegal_op output and trap-to-halt.
module unidad_de_control
   import unidad_de_control_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        V,
   input  logic        Z,
   input  logic        N,
   input  logic        C,
   input  logic [15:0] busA,
   output logic [3:0]  FS,
   output logic [2:0]  addrD,
   output logic [2:0]  addrA,
   output logic [2:0]  addrB,
   output logic        MBSelect,
   output logic        MDSelect,
   output logic        RW,
   output logic        MW,
   output logic [15:0] constin,
   output logic        halted
`ifdef CONTROL_TRAP_EN
   ,
   output logic        illegal_op
`endif
);

   stateT       state;
   logic [15:0] pc;
   logic [15:0] ir;

   logic [3:0]  decFs;
   logic        decMb;
   logic        decMd;
   logic        decRw;
   logic        decMw;
   logic        decBranchTaken;
   logic        decJumpTaken;
   logic        decHaltReq;
`ifdef CONTROL_TRAP_EN
   logic        decTrapReq;
`endif

   decodificador_instr uDecoder (
      .state       (state),
      .opClass     (ir[15:13]),
      .subOp       (ir[12:9]),
      .V           (V),
      .Z           (Z),
      .N           (N),
      .C           (C),
      .fs          (decFs),
      .mbSelect    (decMb),
      .mdSelect    (decMd),
      .rw          (decRw),
      .mw          (decMw),
      .branchTaken (decBranchTaken),
      .jumpTaken   (decJumpTaken),
      .haltReq     (decHaltReq)
`ifdef CONTROL_TRAP_EN
      ,
      .trapReq     (decTrapReq)
`endif
   );

   // Register fields go straight to the datapath; reset forces an idle control word.
   assign imem_addr = pc;
   assign imem_req  = (state == FETCH) && !reset;
   assign addrD     = ir[8:6];
   assign addrA     = ir[5:3];
   assign addrB     = ir[2:0];
   assign constin   = {13'd0, ir[2:0]};
   assign FS        = reset ? 4'd0 : decFs;
   assign MBSelect  = decMb & ~reset;
   assign MDSelect  = decMd & ~reset;
   assign RW        = decRw & ~reset;
   assign MW        = decMw & ~reset;

   // FETCH waits for the ack, EXEC lasts one cycle and resolves the next PC, HALT is terminal.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         ir     <= 16'd0;
         halted <= 1'b0;
`ifdef CONTROL_TRAP_EN
         illegal_op <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_data;
                  pc    <= pc + 16'd1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               state <= FETCH;
               if (decBranchTaken) begin
                  pc <= branchTarget(pc, {ir[8:6], ir[2:0]});
               end else if (decJumpTaken) begin
                  pc <= busA;
               end
               if (decHaltReq) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
`ifdef CONTROL_TRAP_EN
               if (decTrapReq) begin
                  state      <= HALT;
                  halted     <= 1'b1;
                  illegal_op <= 1'b1;
               end
`endif
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unidad_de_control.sv
// Self-checking bench for unidad_de_control: directed vector table, hand-written corner
// sequences and randomized instructions checked against an architectural reference model.
module tb_unidad_de_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        V, Z, N, C;
   logic [15:0] busA;
   logic [3:0]  FS;
   logic [2:0]  addrD, addrA, addrB;
   logic        MBSelect, MDSelect, RW, MW;
   logic [15:0] constin;
   logic        halted;
`ifdef CONTROL_TRAP_EN
   logic        illegalOp;
`endif

   always #5 clk = ~clk;

   unidad_de_control #(.RESET_PC(16'h0010)) dut (
      .clk       (clk),
      .reset     (reset),
      .imem_addr (imem_addr),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .V         (V),
      .Z         (Z),
      .N         (N),
      .C         (C),
      .busA      (busA),
      .FS        (FS),
      .addrD     (addrD),
      .addrA     (addrA),
      .addrB     (addrB),
      .MBSelect  (MBSelect),
      .MDSelect  (MDSelect),
      .RW        (RW),
      .MW        (MW),
      .constin   (constin),
      .halted    (halted)
`ifdef CONTROL_TRAP_EN
      ,
      .illegal_op(illegalOp)
`endif
   );

   typedef struct {
      logic [3:0] fs;
      logic       mb;
      logic       md;
      logic       rw;
      logic       mw;
   } ctrlT;

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  flags;
      logic [15:0] busVal;
      int          waitCycles;
      logic [3:0]  fs;
      logic        mb;
      logic        md;
      logic        rw;
      logic        mw;
      logic [15:0] nextPc;
   } vecT;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] modelPc;
   vecT         vecs[16];
   ctrlT        expCtrl;
   ctrlT        idleCtrl;
   logic [15:0] rndInstr;
   logic [15:0] rndBus;
   logic [3:0]  rndFlags;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Architectural view of the spec: what the datapath should see for a given instruction.
   function automatic ctrlT modelCtrl(input logic [15:0] ins);
      ctrlT c;
      c = '{fs: 4'd0, mb: 1'b0, md: 1'b0, rw: 1'b0, mw: 1'b0};
      case (ins[15:13])
         3'b000: begin c.fs = ins[12:9]; c.rw = 1'b1; end
         3'b001: begin c.md = 1'b1; c.rw = 1'b1; end
         3'b010: c.mw = 1'b1;
         3'b100: begin c.fs = ins[12:9]; c.mb = 1'b1; c.rw = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // Flags are packed {V,Z,N,C}; arithmetic is done on ints and truncated to 16 bits.
   function automatic logic [15:0] modelNextPc(input logic [15:0] pc, input logic [15:0] ins,
                                               input logic [3:0] fl, input logic [15:0] bv);
      int nxt;
      int off;
      bit taken;
      nxt = int'(pc) + 1;
      taken = 1'b0;
      if (ins[15:13] == 3'b110) begin
         off = int'({ins[8:6], ins[2:0]});
         if (off > 31) off = off - 64;
         case (ins[12:9])
            4'd0: taken = fl[2];
            4'd1: taken = fl[1];
            4'd2: taken = fl[0];
            4'd3: taken = fl[3];
            4'd4: taken = 1'b1;
            default: taken = 1'b0;
         endcase
         if (taken) nxt = nxt + off;
      end else if (ins[15:13] == 3'b111) begin
         nxt = int'(bv);
      end
      return 16'(nxt);
   endfunction

   // One full instruction: optional stall cycles, the ack cycle, then the EXEC cycle.
   task automatic applyStimulus(input logic [15:0] instr, input logic [3:0] flags,
                                input logic [15:0] busVal, input int waitCycles,
                                input logic ackInExec, input ctrlT exp);
      for (int w = 0; w < waitCycles; w++) begin
         imem_ack  = 1'b0;
         imem_data = 16'($urandom);
         #3;
         checkOutput("stallReq", 16'(imem_req), 16'd1);
         checkOutput("stallAddr", imem_addr, modelPc);
         checkOutput("stallRwMw", 16'({RW, MW}), 16'd0);
         @(posedge clk); #1;
      end
      imem_ack  = 1'b1;
      imem_data = instr;
      #3;
      checkOutput("fetchReq", 16'(imem_req), 16'd1);
      checkOutput("fetchAddr", imem_addr, modelPc);
      @(posedge clk); #1;
      imem_ack     = ackInExec;
      imem_data    = ~instr;
      {V, Z, N, C} = flags;
      busA         = busVal;
      #3;
      checkOutput("execFS", 16'(FS), 16'(exp.fs));
      checkOutput("execMB", 16'(MBSelect), 16'(exp.mb));
      checkOutput("execMD", 16'(MDSelect), 16'(exp.md));
      checkOutput("execRW", 16'(RW), 16'(exp.rw));
      checkOutput("execMW", 16'(MW), 16'(exp.mw));
      checkOutput("execAddrD", 16'(addrD), 16'(instr[8:6]));
      checkOutput("execAddrA", 16'(addrA), 16'(instr[5:3]));
      checkOutput("execAddrB", 16'(addrB), 16'(instr[2:0]));
      checkOutput("execConst", constin, {13'd0, instr[2:0]});
      checkOutput("execReq", 16'(imem_req), 16'd0);
      @(posedge clk); #1;
      imem_ack = 1'b0;
   endtask

   task automatic doReset();
      reset    = 1'b1;
      imem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #3;
      checkOutput("resetReq", 16'(imem_req), 16'd0);
      checkOutput("resetRwMw", 16'({RW, MW}), 16'd0);
      checkOutput("resetFS", 16'(FS), 16'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("resetHalted", 16'(halted), 16'd0);
      checkOutput("resetAddr", imem_addr, 16'h0010);
      modelPc = 16'h0010;
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_data = 16'd0;
      V = 1'b0; Z = 1'b0; N = 1'b0; C = 1'b0; busA = 16'd0;
      idleCtrl = '{fs: 4'd0, mb: 1'b0, md: 1'b0, rw: 1'b0, mw: 1'b0};

      // instr, {V,Z,N,C}, busA, wait, FS, MB, MD, RW, MW, next PC
      vecs[0]  = '{16'h04D1, 4'h0, 16'h0000, 0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0011};
      vecs[1]  = '{16'h2B48, 4'h0, 16'h0000, 1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0012};
      vecs[2]  = '{16'h401C, 4'h0, 16'h0000, 2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0013};
      vecs[3]  = '{16'h8A8F, 4'h0, 16'h0000, 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0014};
      vecs[4]  = '{16'hE020, 4'h0, 16'h0005, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005};
      vecs[5]  = '{16'hC1C6, 4'h4, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004};
      vecs[6]  = '{16'hE020, 4'h0, 16'h0005, 1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005};
      vecs[7]  = '{16'hC1C6, 4'hB, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006};
      vecs[8]  = '{16'hC805, 4'h0, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000C};
      vecs[9]  = '{16'hCA05, 4'hF, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000D};
      vecs[10] = '{16'hC5C7, 4'h1, 16'h0000, 3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000D};
      vecs[11] = '{16'hC602, 4'h8, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010};
      vecs[12] = '{16'hC202, 4'hD, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011};
      vecs[13] = '{16'hE020, 4'h0, 16'hFFFF, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};
      vecs[14] = '{16'h04D1, 4'h0, 16'h0000, 1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[15] = '{16'hC9C6, 4'h0, 16'h0000, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};

      doReset();

      for (int i = 0; i < 16; i++) begin
         expCtrl = '{fs: vecs[i].fs, mb: vecs[i].mb, md: vecs[i].md, rw: vecs[i].rw, mw: vecs[i].mw};
         applyStimulus(vecs[i].instr, vecs[i].flags, vecs[i].busVal, vecs[i].waitCycles, 1'b0, expCtrl);
         modelPc = vecs[i].nextPc;
      end

`ifndef CONTROL_TRAP_EN
      // Illegal classes behave as a NOP and fall through to the next instruction.
      applyStimulus(16'h6053, 4'hF, 16'h1234, 0, 1'b0, idleCtrl);
      modelPc = modelPc + 16'd1;
      applyStimulus(16'hA000, 4'hF, 16'h1234, 1, 1'b0, idleCtrl);
      modelPc = modelPc + 16'd1;
      checkOutput("nopHalted", 16'(halted), 16'd0);
`endif

      // Stall with ack low, then reset mid-fetch while a late ack arrives.
      for (int s = 0; s < 2; s++) begin
         imem_ack = 1'b0;
         #3;
         checkOutput("stallHoldReq", 16'(imem_req), 16'd1);
         checkOutput("stallHoldAddr", imem_addr, modelPc);
         checkOutput("stallHoldRw", 16'({RW, MW}), 16'd0);
         @(posedge clk); #1;
      end
      reset     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 16'h04D1;
      #3;
      checkOutput("midResetReq", 16'(imem_req), 16'd0);
      checkOutput("midResetRw", 16'({RW, MW}), 16'd0);
      @(posedge clk); #1;
      reset    = 1'b0;
      imem_ack = 1'b0;
      modelPc  = 16'h0010;
      for (int s = 0; s < 2; s++) begin
         #3;
         checkOutput("postResetReq", 16'(imem_req), 16'd1);
         checkOutput("postResetAddr", imem_addr, modelPc);
         checkOutput("postResetRw", 16'({RW, MW}), 16'd0);
         @(posedge clk); #1;
      end
      applyStimulus(16'h2B48, 4'h0, 16'h0000, 0, 1'b1, modelCtrl(16'h2B48));
      modelPc = modelPc + 16'd1;

      // HALT is sticky and ignores further acks.
      applyStimulus(16'hFE00, 4'hF, 16'h0000, 0, 1'b1, idleCtrl);
      for (int h = 0; h < 4; h++) begin
         imem_ack = 1'b1;
         #3;
         checkOutput("haltFlag", 16'(halted), 16'd1);
         checkOutput("haltReq", 16'(imem_req), 16'd0);
         checkOutput("haltRwMw", 16'({RW, MW}), 16'd0);
         @(posedge clk); #1;
      end
      doReset();

`ifdef CONTROL_TRAP_EN
      // Illegal class traps: sticky illegal_op and halt until reset.
      applyStimulus(16'h6053, 4'hF, 16'h0000, 0, 1'b0, idleCtrl);
      for (int h = 0; h < 3; h++) begin
         imem_ack = 1'b1;
         #3;
         checkOutput("trapIllegal", 16'(illegalOp), 16'd1);
         checkOutput("trapHalted", 16'(halted), 16'd1);
         checkOutput("trapReq", 16'(imem_req), 16'd0);
         @(posedge clk); #1;
      end
      doReset();
      checkOutput("trapCleared", 16'(illegalOp), 16'd0);
`endif

      // Randomized instruction stream against the architectural model.
      for (int i = 0; i < 250; i++) begin
         rndInstr = 16'($urandom);
         if (rndInstr[15:13] == 3'b111 && rndInstr[12:9] == 4'hF) rndInstr[12:9] = 4'h0;
`ifdef CONTROL_TRAP_EN
         if (rndInstr[15:13] == 3'b011 || rndInstr[15:13] == 3'b101) rndInstr[15:13] = 3'b000;
`endif
         rndFlags = 4'($urandom);
         rndBus   = 16'($urandom);
         applyStimulus(rndInstr, rndFlags, rndBus, int'($urandom_range(0, 3)),
                       1'($urandom), modelCtrl(rndInstr));
         modelPc = modelNextPc(modelPc, rndInstr, rndFlags, rndBus);
      end
      #3;
      checkOutput("finalAddr", imem_addr, modelPc);
      checkOutput("finalHalted", 16'(halted), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
